// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period and high-time measurement against a reference clock
//
// Purpose:
//   Measures the rise-to-rise period and rise-to-fall high time of an
//   asynchronous PWM input in refClock cycles. A result is published on
//   every rising edge that closes a complete period. If the counter would
//   exceed its range, the block raises a sticky overflow flag and restarts.
//
// Ports:
//   refClock      in   single clock, rising edge active
//   nReset        in   asynchronous active-low reset
//   enCapture     in   measurement enable; low forces IDLE on the next edge
//   pwmIn         in   asynchronous PWM input
//   period        out  last complete period, rise to rise (CNT_WIDTH)
//   highTime      out  high time of that period, rise to fall (CNT_WIDTH)
//   eventCapture  out  one-cycle pulse when period/highTime update
//   captureValid  out  period/highTime hold a valid measurement
//   overflow      out  sticky: no edge seen for 2^CNT_WIDTH-1 cycles
//   pwmLevel      out  synchronized pwmIn level

module pwm_capture #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 refClock,
  input  logic                 nReset,
  input  logic                 enCapture,
  input  logic                 pwmIn,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] highTime,
  output logic                 eventCapture,
  output logic                 captureValid,
  output logic                 overflow,
  output logic                 pwmLevel
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MEAS_HIGH = 2'd1,
    ST_MEAS_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   prev_q, prev_d;
  logic [1:0]             fill_q, fill_d;
  logic                   armed_q, armed_d;
  logic [CNT_WIDTH-1:0]   period_cnt_q, period_cnt_d;
  logic [CNT_WIDTH-1:0]   high_latch_q, high_latch_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic [CNT_WIDTH-1:0]   high_time_q, high_time_d;
  logic                   event_q, event_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;

  logic                   rise;
  logic                   fall;
  logic                   measuring;
  logic                   cnt_at_max;

  // fill_q[1] marks that sync2_q holds a real sample of pwmIn rather than
  // its reset value. armed_q is set once such a sample reads low, so an
  // input that is already high when reset releases is not taken as a rise.
  assign rise       = sync2_q & ~prev_q & armed_q;
  assign fall       = ~sync2_q & prev_q;
  assign measuring  = (state_q != ST_IDLE);
  assign cnt_at_max = (period_cnt_q == CNT_MAX);

  always_comb begin
    sync1_d = pwmIn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~sync2_q);
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_latch_d = high_latch_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    event_d      = 1'b0;
    valid_d      = valid_q;
    ovf_d        = ovf_q;

    if (!enCapture) begin
      // Results and the overflow flag survive a disable; only the live
      // measurement is discarded.
      state_d      = ST_IDLE;
      period_cnt_d = CNT_ZERO;
      high_latch_d = CNT_ZERO;
      valid_d      = 1'b0;
    end else begin
      if (rise) begin
        period_cnt_d = CNT_ONE;
      end else if (measuring) begin
        period_cnt_d = period_cnt_q + CNT_ONE;
      end

      case (state_q)
        ST_IDLE: begin
          // The first rise only starts a measurement; nothing is published.
          if (rise) begin
            state_d = ST_MEAS_HIGH;
          end
        end
        ST_MEAS_HIGH: begin
          if (cnt_at_max) begin
            state_d      = ST_IDLE;
            period_cnt_d = CNT_ZERO;
            valid_d      = 1'b0;
            ovf_d        = 1'b1;
          end else if (fall) begin
            high_latch_d = period_cnt_q;
            state_d      = ST_MEAS_LOW;
          end
        end
        ST_MEAS_LOW: begin
          // A rise with the counter at its maximum is still a legal period.
          if (rise) begin
            period_d    = period_cnt_q;
            high_time_d = high_latch_q;
            event_d     = 1'b1;
            valid_d     = 1'b1;
            ovf_d       = 1'b0;
            state_d     = ST_MEAS_HIGH;
          end else if (cnt_at_max) begin
            state_d      = ST_IDLE;
            period_cnt_d = CNT_ZERO;
            valid_d      = 1'b0;
            ovf_d        = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge refClock or negedge nReset) begin
    if (!nReset) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      fill_q       <= 2'b00;
      armed_q      <= 1'b0;
      period_cnt_q <= CNT_ZERO;
      high_latch_q <= CNT_ZERO;
      period_q     <= CNT_ZERO;
      high_time_q  <= CNT_ZERO;
      event_q      <= 1'b0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      period_cnt_q <= period_cnt_d;
      high_latch_q <= high_latch_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      event_q      <= event_d;
      valid_q      <= valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign period       = period_q;
  assign highTime     = high_time_q;
  assign eventCapture = event_q;
  assign captureValid = valid_q;
  assign overflow     = ovf_q;
  assign pwmLevel     = sync2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture with an edge-time reference model

module tb_pwm_capture;

  localparam int W   = 8;
  localparam int MAX = 255;

  typedef struct packed {
    int          cyc;
    logic [7:0]  per;
    logic [7:0]  hi;
    logic        ovf;
  } ev_t;

  logic         refClock = 1'b0;
  logic         nReset;
  logic         enCapture;
  logic         pwmIn;
  logic [W-1:0] period;
  logic [W-1:0] highTime;
  logic         eventCapture;
  logic         captureValid;
  logic         overflow;
  logic         pwmLevel;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: edge indices of the open measurement
  bit         active = 1'b0;
  int         last_rise = 0;
  int         last_fall = 0;
  logic [7:0] exp_per = '0;
  logic [7:0] exp_hi  = '0;
  ev_t        exp_q[$];
  ev_t        ev_q[$];
  ev_t        mon_e;
  ev_t        got;
  ev_t        want;

  pwm_capture #(.CNT_WIDTH(W)) dut (
    .refClock     (refClock),
    .nReset       (nReset),
    .enCapture    (enCapture),
    .pwmIn        (pwmIn),
    .period       (period),
    .highTime     (highTime),
    .eventCapture (eventCapture),
    .captureValid (captureValid),
    .overflow     (overflow),
    .pwmLevel     (pwmLevel)
  );

  always #5 refClock = ~refClock;

  always @(posedge refClock) cyc <= cyc + 1;

  always @(posedge refClock) begin
    #1;
    if (eventCapture === 1'b1) begin
      mon_e = '{cyc: cyc, per: period, hi: highTime, ovf: overflow};
      ev_q.push_back(mon_e);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // One period: high for h samples, low for p-h samples. The rise is the
  // first posedge that samples pwmIn high; the matching result must appear
  // two edges later, carrying the rise-to-rise and rise-to-fall distances.
  task automatic drive_period(input int p, input int h);
    int s;
    @(negedge refClock);
    pwmIn = 1'b1;
    s = cyc + 1;
    if (!enCapture || !nReset) begin
      active = 1'b0;
    end else begin
      if (active && (s - last_rise) <= MAX) begin
        exp_per = 8'(s - last_rise);
        exp_hi  = 8'(last_fall - last_rise);
        want = '{cyc: s + 2, per: exp_per, hi: exp_hi, ovf: 1'b0};
        exp_q.push_back(want);
      end
      active    = 1'b1;
      last_rise = s;
      last_fall = s + h;
    end
    repeat (h - 1) @(negedge refClock);
    @(negedge refClock);
    pwmIn = 1'b0;
    repeat (p - h - 1) @(negedge refClock);
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge refClock);
      #1;
    end
  endtask

  task automatic test_reset;
    nReset    = 1'b0;
    enCapture = 1'b1;
    pwmIn     = 1'b0;
    repeat (3) @(negedge refClock);
    checks++;
    if ({period, highTime, eventCapture, captureValid, overflow, pwmLevel} !== 20'b0) begin
      errors++;
      $display("FAIL reset_outputs: got per=%0d hi=%0d ev=%b vld=%b ovf=%b lvl=%b, expected all zero",
               period, highTime, eventCapture, captureValid, overflow, pwmLevel);
    end
    @(negedge refClock);
    nReset = 1'b1;
    active = 1'b0;
    repeat (4) @(negedge refClock);
  endtask

  task automatic test_basic;
    repeat (5) drive_period(10, 3);
    repeat (3) @(posedge refClock);
    #1;
    checks++;
    if (captureValid !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid: got %b, expected 1", captureValid);
    end
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      got = ev_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL basic_event: got cyc=%0d per=%0d hi=%0d ovf=%b, expected cyc=%0d per=%0d hi=%0d ovf=%b",
                 got.cyc, got.per, got.hi, got.ovf, want.cyc, want.per, want.hi, want.ovf);
      end
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic test_min_period;
    repeat (6) drive_period(2, 1);
    repeat (3) @(posedge refClock);
    #1;
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL min_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      got = ev_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL min_event: got cyc=%0d per=%0d hi=%0d ovf=%b, expected cyc=%0d per=%0d hi=%0d ovf=%b",
                 got.cyc, got.per, got.hi, got.ovf, want.cyc, want.per, want.hi, want.ovf);
      end
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random;
    int p;
    int h;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) p = MAX;
      else        p = int'($urandom_range(60, 2));
      h = int'($urandom_range(p - 1, 1));
      drive_period(p, h);
    end
    repeat (3) @(posedge refClock);
    #1;
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      got = ev_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_event: got cyc=%0d per=%0d hi=%0d ovf=%b, expected cyc=%0d per=%0d hi=%0d ovf=%b",
                 got.cyc, got.per, got.hi, got.ovf, want.cyc, want.per, want.hi, want.ovf);
      end
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  // Rise, then stuck high: the counter reaches its maximum 256 edges after
  // the rise is first sampled, so overflow appears after edge s+257.
  task automatic test_overflow;
    int s;
    s = 0;
    fork
      drive_period(280, 270);
      begin
        wait (pwmIn === 1'b1);
        s = cyc + 1;
        wait_edge(s + 3);
        checks++;
        if (captureValid !== 1'b1) begin
          errors++;
          $display("FAIL ovf_valid_before: got %b, expected 1", captureValid);
        end
        wait_edge(s + 256);
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early: got overflow=%b at edge s+256, expected 0", overflow);
        end
        wait_edge(s + 257);
        checks++;
        if ({overflow, captureValid} !== 2'b10) begin
          errors++;
          $display("FAIL ovf_set: got overflow=%b valid=%b, expected overflow=1 valid=0", overflow, captureValid);
        end
        checks++;
        if (period !== exp_per || highTime !== exp_hi) begin
          errors++;
          $display("FAIL ovf_hold: got per=%0d hi=%0d, expected per=%0d hi=%0d", period, highTime, exp_per, exp_hi);
        end
      end
    join
    drive_period(20, 15);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b, expected 1", overflow);
    end
    repeat (3) drive_period(20, 15);
    repeat (3) @(posedge refClock);
    #1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b, expected 0", overflow);
    end
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ovf_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      got = ev_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL ovf_event: got cyc=%0d per=%0d hi=%0d ovf=%b, expected cyc=%0d per=%0d hi=%0d ovf=%b",
                 got.cyc, got.per, got.hi, got.ovf, want.cyc, want.per, want.hi, want.ovf);
      end
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic test_enable;
    logic [7:0] hold_p;
    logic [7:0] hold_h;
    repeat (2) drive_period(12, 5);
    @(negedge refClock);
    enCapture = 1'b0;
    hold_p = exp_per;
    hold_h = exp_hi;
    @(posedge refClock);
    #1;
    checks++;
    if (captureValid !== 1'b0) begin
      errors++;
      $display("FAIL en_valid_drop: got %b, expected 0", captureValid);
    end
    repeat (3) drive_period(9, 4);
    checks++;
    if (period !== hold_p || highTime !== hold_h || overflow !== 1'b0 || captureValid !== 1'b0) begin
      errors++;
      $display("FAIL en_hold: got per=%0d hi=%0d ovf=%b vld=%b, expected per=%0d hi=%0d ovf=0 vld=0",
               period, highTime, overflow, captureValid, hold_p, hold_h);
    end
    @(negedge refClock);
    enCapture = 1'b1;
    repeat (3) @(negedge refClock);
    repeat (3) drive_period(14, 6);
    repeat (3) @(posedge refClock);
    #1;
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL en_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      got = ev_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL en_event: got cyc=%0d per=%0d hi=%0d ovf=%b, expected cyc=%0d per=%0d hi=%0d ovf=%b",
                 got.cyc, got.per, got.hi, got.ovf, want.cyc, want.per, want.hi, want.ovf);
      end
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic test_async_reset;
    repeat (3) drive_period(10, 3);
    repeat (2) @(negedge refClock);
    #1;
    nReset = 1'b0;
    #1;
    checks++;
    if ({period, highTime, eventCapture, captureValid, overflow, pwmLevel} !== 20'b0) begin
      errors++;
      $display("FAIL areset_outputs: got per=%0d hi=%0d ev=%b vld=%b ovf=%b lvl=%b, expected all zero",
               period, highTime, eventCapture, captureValid, overflow, pwmLevel);
    end
    active = 1'b0;
    pwmIn  = 1'b1;
    @(negedge refClock);
    nReset = 1'b1;
    repeat (10) @(negedge refClock);
    pwmIn = 1'b0;
    repeat (4) @(negedge refClock);
    repeat (3) drive_period(16, 7);
    repeat (3) @(posedge refClock);
    #1;
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL areset_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      got = ev_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL areset_event: got cyc=%0d per=%0d hi=%0d ovf=%b, expected cyc=%0d per=%0d hi=%0d ovf=%b",
                 got.cyc, got.per, got.hi, got.ovf, want.cyc, want.per, want.hi, want.ovf);
      end
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  initial begin
    nReset    = 1'b0;
    enCapture = 1'b1;
    pwmIn     = 1'b0;
    test_reset();
    test_basic();
    test_min_period();
    test_random();
    test_overflow();
    test_enable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
